// File: rtl/mult_sequencer.sv
// mult_sequencer: drives a run of multiplier launches with consecutive operands
// (base, base+1, ...), collects each product, and hands it to a consumer over a
// valid/ready handshake. A launch that never sees mult_done within TIMEOUT wait
// cycles aborts the run and raises a sticky error flag.
module mult_sequencer #(
    parameter int W_A      = 7,
    parameter int W_PP     = 11,
    parameter int INIT_CYC = 2,
    parameter int TIMEOUT  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W_A-1:0]  base,
    input  logic [3:0]      count,
    input  logic [W_PP-1:0] mult_pp,
    input  logic            mult_done,
    output logic [W_A-1:0]  mult_A,
    output logic            mult_init,
    output logic [W_PP-1:0] col_data,
    output logic            col_valid,
    input  logic            col_ready,
    output logic            busy,
    output logic            finished,
    output logic            err
);

    localparam int IW = $clog2(INIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HOLD,
        S_NEXT
    } state_t;

    state_t          state;
    logic [W_A-1:0]  operand;
    logic [3:0]      remaining;
    logic [IW-1:0]   init_cnt;
    logic [TW-1:0]   wait_cnt;

    // The operand register is the multiplier input; it only changes in IDLE and NEXT.
    assign mult_A = operand;

    // Sequencer FSM with all outputs registered.
    // NOTE: every register here uses non-blocking assignment so all updates in a
    // clock edge see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            operand   <= '0;
            remaining <= '0;
            init_cnt  <= '0;
            wait_cnt  <= '0;
            col_data  <= '0;
            col_valid <= 1'b0;
            mult_init <= 1'b0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            err       <= 1'b0;
        end else begin
            // finished is a single-cycle pulse unless a branch below raises it.
            finished <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        operand   <= base;
                        remaining <= count;
                        err       <= 1'b0;
                        if (count != 4'd0) begin
                            state     <= S_LAUNCH;
                            mult_init <= 1'b1;
                            busy      <= 1'b1;
                            init_cnt  <= '0;
                        end else begin
                            finished <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (init_cnt == INIT_LAST) begin
                        mult_init <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= S_WAIT;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                end
                S_WAIT: begin
                    if (mult_done) begin
                        col_data  <= mult_pp;
                        col_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abort: no product, no finished pulse, error stays until next start.
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (col_ready) begin
                        col_valid <= 1'b0;
                        state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    remaining <= remaining - 4'd1;
                    operand   <= operand + W_A'(1);
                    if (remaining == 4'd1) begin
                        finished <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        mult_init <= 1'b1;
                        init_cnt  <= '0;
                        state     <= S_LAUNCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer. A small multiplier model returns
// mult_A*11 one cycle-wide, ten cycles after mult_init falls.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  base;
    logic [3:0]  count;
    logic [10:0] mult_pp;
    logic        mult_done;
    logic [6:0]  mult_A;
    logic        mult_init;
    logic [10:0] col_data;
    logic        col_valid;
    logic        col_ready;
    logic        busy;
    logic        finished;
    logic        err;

    int total = 0;
    int bad   = 0;

    bit model_en = 1'b1;
    bit prev_init = 1'b0;
    int dly = 0;

    always #5 clk = ~clk;

    mult_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .count     (count),
        .mult_pp   (mult_pp),
        .mult_done (mult_done),
        .mult_A    (mult_A),
        .mult_init (mult_init),
        .col_data  (col_data),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .busy      (busy),
        .finished  (finished),
        .err       (err)
    );

    // Multiplier model: done pulse ten cycles after mult_init falls; product is
    // an obvious junk value whenever done is low.
    always @(negedge clk) begin
        mult_done = 1'b0;
        mult_pp   = 11'h7ff;
        if (model_en && prev_init && !mult_init) begin
            dly = 10;
        end else if (dly != 0) begin
            dly = dly - 1;
            if (dly == 0) begin
                mult_done = 1'b1;
                mult_pp   = 11'(mult_A * 11);
            end
        end
        prev_init = mult_init;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [6:0] b, input logic [3:0] c);
        start = 1'b1;
        base  = b;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!col_valid && n < 100);
        check({tag, "_valid_seen"}, 32'(col_valid), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        check({tag, "_finished"}, 32'(finished), 1);
        check({tag, "_err"}, 32'(err), 0);
        @(negedge clk);
        check({tag, "_finished_pulse"}, 32'(finished), 0);
    endtask

    initial begin
        logic [31:0] exp1[4] = '{33, 44, 55, 66};
        logic [31:0] exp2[3] = '{1386, 1397, 0};
        logic [31:0] expa2[3] = '{126, 127, 0};
        bit   flag;
        int   cyc;

        reset = 1'b0;
        start = 1'b0;
        base = '0;
        count = '0;
        col_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, mult_init, col_valid, finished, err, mult_A, col_data}, 0);
        reset = 1'b1;
        flag = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if ({busy, mult_init, col_valid, finished, err, mult_A, col_data} !== '0) flag = 1'b0;
        end
        check("post_rst_quiet", 32'(flag), 1);

        // Run 1: base 3, four products, consumer always ready.
        col_ready = 1'b1;
        do_start(7'd3, 4'd4);
        check("r1_init_latency", 32'(mult_init), 1);
        check("r1_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            wait_valid("r1");
            check("r1_data", 32'(col_data), exp1[i]);
            check("r1_mult_A", 32'(mult_A), 3 + i);
            if (i == 0) do_start(7'd50, 4'd9);  // ignored while busy
        end
        wait_idle("r1");

        // Run 2: operand wraps 127 -> 0.
        do_start(7'd126, 4'd3);
        for (int i = 0; i < 3; i++) begin
            wait_valid("r2");
            check("r2_data", 32'(col_data), exp2[i]);
            check("r2_mult_A", 32'(mult_A), expa2[i]);
        end
        wait_idle("r2");

        // Run 3: zero-length run.
        do_start(7'd9, 4'd0);
        check("r3_finished", 32'(finished), 1);
        check("r3_busy", 32'(busy), 0);
        flag = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (mult_init || busy || finished) flag = 1'b0;
        end
        check("r3_quiet_after", 32'(flag), 1);

        // Run 4: consumer stalls for 20 cycles in HOLD.
        col_ready = 1'b0;
        do_start(7'd10, 4'd2);
        wait_valid("r4");
        flag = 1'b1;
        repeat (20) begin
            if (!col_valid || col_data !== 11'd110 || mult_init || mult_A !== 7'd10) flag = 1'b0;
            @(negedge clk);
        end
        check("r4_hold_stable", 32'(flag), 1);
        col_ready = 1'b1;
        @(negedge clk);
        check("r4_valid_drop", 32'(col_valid), 0);
        check("r4_no_init_yet", 32'(mult_init), 0);
        @(negedge clk);
        check("r4_next_init", 32'(mult_init), 1);
        check("r4_next_A", 32'(mult_A), 11);
        wait_valid("r4b");
        check("r4_data2", 32'(col_data), 121);
        wait_idle("r4");

        // Run 5: multiplier never answers -> timeout after INIT_CYC + TIMEOUT cycles.
        model_en = 1'b0;
        do_start(7'd5, 4'd2);
        cyc = 0;
        flag = 1'b1;
        while (!err && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (finished || col_valid) flag = 1'b0;
        end
        check("r5_timeout_cycle", 32'(cyc), 34);
        check("r5_idle", 32'(busy), 0);
        check("r5_no_fin_no_valid", 32'(flag), 1);
        @(negedge clk);
        check("r5_err_sticky", 32'(err), 1);
        check("r5_no_fin_later", 32'(finished), 0);
        model_en = 1'b1;
        do_start(7'd1, 4'd1);
        check("r5_err_cleared", 32'(err), 0);
        wait_valid("r5b");
        check("r5_data", 32'(col_data), 11);
        wait_idle("r5b");

        // Run 6: reset asserted during WAIT of the second product.
        do_start(7'd20, 4'd3);
        wait_valid("r6");
        check("r6_data", 32'(col_data), 220);
        do_start(7'd99, 4'd7);  // ignored while busy
        cyc = 0;
        while (!mult_init && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        while (mult_init && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("r6_reached_wait", 32'(mult_init == 1'b0 && busy == 1'b1 && mult_A == 7'd21), 1);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        base  = 7'd40;
        count = 4'd5;
        #1;
        check("r6_async_rst", {busy, mult_init, col_valid, finished, err, mult_A, col_data}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        flag = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if ({busy, mult_init, col_valid, finished, err, mult_A, col_data} !== '0) flag = 1'b0;
        end
        check("r6_quiet_after_rst", 32'(flag), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
